// File: rtl/diff_ddr_eye_tracker.sv
// diff_ddr_eye_tracker
//   Keeps the data IDELAY of a differential DDR deserializer centred in the eye.
//   The tracker delay line, which samples the complement pin, is parked
//   alternately OFFSET taps before and after the data delay. At each point,
//   mismatches between the data and tracker samples are counted over a window.
//   After each early/late pair the data delay moves one tap toward the cleaner
//   side.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : run tracking; low aborts to IDLE
//   data, tracker         : deserialized nibbles (tracker is inverted polarity)
//   delay_config__op      : 0 none, 1 load (only 0/1 issued), one cycle per load
//   delay_config__select  : 0 data delay, 1 tracker delay
//   delay_config__value   : tap value for a load
//   data_delay            : currently loaded data tap
//   locked                : eye centred and stable
//   early_errors/late_errors : last completed window error counts
module diff_ddr_eye_tracker #(
  parameter int OFFSET      = 16,
  parameter int WINDOW_LOG2 = 8,
  parameter int SETTLE      = 8,
  parameter int HYSTERESIS  = 4,
  parameter int INIT_DELAY  = 256,
  parameter int LOCK_ROUNDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             data,
  input  logic [3:0]             tracker,
  output logic [1:0]             delay_config__op,
  output logic                   delay_config__select,
  output logic [8:0]             delay_config__value,
  output logic [8:0]             data_delay,
  output logic                   locked,
  output logic [WINDOW_LOG2+2:0] early_errors,
  output logic [WINDOW_LOG2+2:0] late_errors
);

  localparam int ERR_W    = WINDOW_LOG2 + 3;
  localparam int CNT_W    = (WINDOW_LOG2 > 8) ? WINDOW_LOG2 : 8;
  localparam int STREAK_W = $clog2(LOCK_ROUNDS + 1);
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]    WINDOW_LAST = CNT_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [STREAK_W-1:0] LOCK_MAX    = STREAK_W'(LOCK_ROUNDS);

  typedef enum logic [3:0] {
    IDLE, LOAD_DATA, LOAD_EARLY, SETTLE_E, MEASURE_E,
    LOAD_LATE, SETTLE_L, MEASURE_L, ADJUST
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0]    acc_q, acc_d;
  logic [1:0]          op_q, op_d;
  logic                sel_q, sel_d;
  logic [8:0]          val_q, val_d;
  logic [8:0]          data_delay_q, data_delay_d;
  logic [ERR_W-1:0]    early_q, early_d;
  logic [ERR_W-1:0]    late_q, late_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                locked_q, locked_d;

  // Tracker tap positions, computed one bit wider so under/overflow is visible.
  logic [9:0] early_sum, late_sum;
  logic [8:0] early_tap, late_tap;
  assign early_sum = {1'b0, data_delay_q} - 10'(OFFSET);
  assign late_sum  = {1'b0, data_delay_q} + 10'(OFFSET);
  assign early_tap = early_sum[9] ? 9'd0   : early_sum[8:0];
  assign late_tap  = late_sum[9]  ? 9'd511 : late_sum[8:0];

  // The tracker pin is inverted, so a clean eye gives data == ~tracker.
  logic [3:0]       mism;
  logic [2:0]       err_cnt;
  logic [ERR_W-1:0] acc_sum;
  assign mism    = data ^ ~tracker;
  assign err_cnt = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]);
  assign acc_sum = acc_q + ERR_W'(err_cnt);

  logic [ERR_W:0] early_x, late_x, hyst_x;
  logic           go_up, go_dn;
  assign early_x = {1'b0, early_q};
  assign late_x  = {1'b0, late_q};
  assign hyst_x  = (ERR_W + 1)'(HYSTERESIS);
  assign go_up   = early_x > (late_x + hyst_x);
  assign go_dn   = late_x > (early_x + hyst_x);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    acc_d        = acc_q;
    op_d         = 2'd0;
    sel_d        = sel_q;
    val_d        = val_q;
    data_delay_d = data_delay_q;
    early_d      = early_q;
    late_d       = late_q;
    streak_d     = streak_q;
    locked_d     = locked_q;

    if (!enable) begin
      state_d  = IDLE;
      streak_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:       state_d = LOAD_DATA;
        LOAD_DATA:  state_d = LOAD_EARLY;
        LOAD_EARLY: state_d = SETTLE_E;
        LOAD_LATE:  state_d = SETTLE_L;
        SETTLE_E, SETTLE_L: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = (state_q == SETTLE_E) ? MEASURE_E : MEASURE_L;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MEASURE_E, MEASURE_L: begin
          acc_d = acc_sum;
          if (cnt_q == WINDOW_LAST) begin
            // The final cycle's error is folded in before publishing.
            if (state_q == MEASURE_E) begin
              early_d = acc_sum;
              state_d = LOAD_LATE;
            end else begin
              late_d  = acc_sum;
              state_d = ADJUST;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ADJUST: begin
          state_d = LOAD_DATA;
          // A step blocked by saturation leaves the tap alone and is not a move.
          if (go_up && data_delay_q != 9'd511) begin
            data_delay_d = data_delay_q + 9'd1;
            streak_d     = '0;
          end else if (go_dn && data_delay_q != 9'd0) begin
            data_delay_d = data_delay_q - 9'd1;
            streak_d     = '0;
          end else if (streak_q != LOCK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
          locked_d = (streak_d == LOCK_MAX);
        end
        default: state_d = IDLE;
      endcase
    end

    // Load commands are registered off the next state so op lines up with the
    // LOAD state itself; LOAD_DATA uses the freshly adjusted data delay.
    case (state_d)
      LOAD_DATA: begin
        op_d  = 2'd1;
        sel_d = 1'b0;
        val_d = data_delay_d;
      end
      LOAD_EARLY: begin
        op_d  = 2'd1;
        sel_d = 1'b1;
        val_d = early_tap;
      end
      LOAD_LATE: begin
        op_d  = 2'd1;
        sel_d = 1'b1;
        val_d = late_tap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      op_q         <= 2'd0;
      sel_q        <= 1'b0;
      val_q        <= 9'd0;
      data_delay_q <= 9'(INIT_DELAY);
      early_q      <= '0;
      late_q       <= '0;
      streak_q     <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      op_q         <= op_d;
      sel_q        <= sel_d;
      val_q        <= val_d;
      data_delay_q <= data_delay_d;
      early_q      <= early_d;
      late_q       <= late_d;
      streak_q     <= streak_d;
      locked_q     <= locked_d;
    end
  end

  assign delay_config__op     = op_q;
  assign delay_config__select = sel_q;
  assign delay_config__value  = val_q;
  assign data_delay           = data_delay_q;
  assign locked               = locked_q;
  assign early_errors         = early_q;
  assign late_errors          = late_q;

endmodule

// File: tb/tb_diff_ddr_eye_tracker.sv
// Testbench for diff_ddr_eye_tracker. Two instances share the clock: instance 0
// uses the default INIT_DELAY, instance 1 starts at INIT_DELAY=5. A channel
// model reacts to tracker loads and injects mismatches on the chosen side.
// Expected load commands are queued by the stimulus; a monitor checks each one.
module tb_diff_ddr_eye_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s   [2];
  logic        enable_s  [2];
  logic [3:0]  data_s    [2];
  logic [3:0]  tracker_s [2];
  logic [1:0]  op_s      [2];
  logic        sel_s     [2];
  logic [8:0]  val_s     [2];
  logic [8:0]  dd_s      [2];
  logic        lk_s      [2];
  logic [10:0] ee_s      [2];
  logic [10:0] le_s      [2];

  diff_ddr_eye_tracker u_dut0 (
    .clk(clk), .reset(reset_s[0]), .enable(enable_s[0]),
    .data(data_s[0]), .tracker(tracker_s[0]),
    .delay_config__op(op_s[0]), .delay_config__select(sel_s[0]),
    .delay_config__value(val_s[0]), .data_delay(dd_s[0]), .locked(lk_s[0]),
    .early_errors(ee_s[0]), .late_errors(le_s[0])
  );

  diff_ddr_eye_tracker #(.INIT_DELAY(5)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .enable(enable_s[1]),
    .data(data_s[1]), .tracker(tracker_s[1]),
    .delay_config__op(op_s[1]), .delay_config__select(sel_s[1]),
    .delay_config__value(val_s[1]), .data_delay(dd_s[1]), .locked(lk_s[1]),
    .early_errors(ee_s[1]), .late_errors(le_s[1])
  );

  typedef struct {
    logic        sel;
    logic [8:0]  val;
    int          gap;   // cycles since previous load, 0 = do not check
    logic [8:0]  dd;
    logic        lk;
    logic [10:0] ee;
    logic [10:0] le;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_load [2];

  // channel model state
  logic [8:0] ch_dd    [2];
  bit         ch_early [2];
  int         ch_since [2];
  int         n_early  [2];
  int         n_late   [2];

  function automatic int q_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pop_exp(input int i, output exp_t e);
    if (i == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
  endtask

  function automatic int etap(input int dd);
    return (dd < 16) ? 0 : dd - 16;
  endfunction

  function automatic int ltap(input int dd);
    return (dd + 16 > 511) ? 511 : dd + 16;
  endfunction

  // One round: LOAD_DATA, LOAD_EARLY and (if full) LOAD_LATE.
  task automatic push_round(input int i, input int dd, input bit lk,
                            input int ee_prev, input int le_prev,
                            input int ee_new, input bit first, input bit full);
    exp_t e;
    e.dd = 9'(dd); e.lk = lk; e.ee = 11'(ee_prev); e.le = 11'(le_prev);
    e.sel = 1'b0; e.val = 9'(dd); e.gap = first ? 0 : 266;
    push_exp(i, e);
    e.sel = 1'b1; e.val = 9'(etap(dd)); e.gap = 1;
    push_exp(i, e);
    if (full) begin
      e.val = 9'(ltap(dd)); e.gap = 265; e.ee = 11'(ee_new);
      push_exp(i, e);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic check_reset(input int i, input int dd_init);
    chk($sformatf("dut%0d reset op", i),    int'(op_s[i]),  0);
    chk($sformatf("dut%0d reset sel", i),   int'(sel_s[i]), 0);
    chk($sformatf("dut%0d reset value", i), int'(val_s[i]), 0);
    chk($sformatf("dut%0d reset dd", i),    int'(dd_s[i]),  dd_init);
    chk($sformatf("dut%0d reset locked", i), int'(lk_s[i]), 0);
    chk($sformatf("dut%0d reset early", i), int'(ee_s[i]),  0);
    chk($sformatf("dut%0d reset late", i),  int'(le_s[i]),  0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_empty(input int i, input int budget);
    int n = 0;
    while (q_size(i) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_size(i) != 0) begin
      total++;
      bad++;
      $display("FAIL dut%0d timeout: %0d loads still pending after %0d cycles", i, q_size(i), budget);
      if (i == 0) sb0.delete();
      else        sb1.delete();
    end
  endtask

  // Monitor and channel model, evaluated away from the active edge.
  exp_t mon_e;
  bit   mon_ok;
  int   mon_gap;
  int   err_n;
  bit   inj;
  logic [3:0] d_rand;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (op_s[i] != 2'd0) begin
        total++;
        mon_gap = cyc - last_load[i];
        if (q_size(i) == 0) begin
          bad++;
          $display("FAIL dut%0d unexpected load: got op=%0d sel=%0d val=%0d, required no load",
                   i, op_s[i], sel_s[i], val_s[i]);
        end else begin
          pop_exp(i, mon_e);
          mon_ok = (op_s[i] == 2'd1) && (sel_s[i] == mon_e.sel) && (val_s[i] == mon_e.val) &&
                   (dd_s[i] == mon_e.dd) && (lk_s[i] == mon_e.lk) &&
                   (ee_s[i] == mon_e.ee) && (le_s[i] == mon_e.le) &&
                   (mon_e.gap == 0 || mon_gap == mon_e.gap);
          if (!mon_ok) begin
            bad++;
            $display("FAIL dut%0d load: got op=%0d sel=%0d val=%0d gap=%0d dd=%0d lk=%0d ee=%0d le=%0d; want op=1 sel=%0d val=%0d gap=%0d dd=%0d lk=%0d ee=%0d le=%0d",
                     i, op_s[i], sel_s[i], val_s[i], mon_gap, dd_s[i], lk_s[i], ee_s[i], le_s[i],
                     mon_e.sel, mon_e.val, mon_e.gap, mon_e.dd, mon_e.lk, mon_e.ee, mon_e.le);
          end else begin
            $display("load dut%0d sel=%0d val=%0d gap=%0d dd=%0d lk=%0d ee=%0d le=%0d ok",
                     i, sel_s[i], val_s[i], mon_gap, dd_s[i], lk_s[i], ee_s[i], le_s[i]);
          end
        end
        last_load[i] = cyc;
      end

      // channel: errors follow whichever side the tracker was last parked on
      if (op_s[i] == 2'd1 && sel_s[i] == 1'b0) ch_dd[i] = val_s[i];
      if (op_s[i] == 2'd1 && sel_s[i] == 1'b1) begin
        ch_early[i] = (val_s[i] <= ch_dd[i]);
        ch_since[i] = 0;
      end else begin
        ch_since[i]++;
      end
      err_n = ch_early[i] ? n_early[i] : n_late[i];
      inj = (err_n >= 256) || (ch_since[i] >= 40 && ch_since[i] < 40 + err_n);
      d_rand = 4'($urandom_range(0, 15));
      data_s[i]    = d_rand;
      tracker_s[i] = ~d_rand ^ {3'b000, inj};
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_s[i] = 1'b1; enable_s[i] = 1'b0;
      data_s[i] = 4'h0; tracker_s[i] = 4'hF;
      ch_dd[i] = 9'd0; ch_early[i] = 1'b0; ch_since[i] = 0;
      n_early[i] = 0; n_late[i] = 0; last_load[i] = 0;
    end
    tick(3);
    check_reset(0, 256);
    check_reset(1, 5);

    // Clean eye: no moves, lock after the fourth ADJUST.
    for (int k = 0; k < 5; k++)
      push_round(0, 256, k >= 4, 0, 0, 0, k == 0, k < 4);
    enable_s[0] = 1'b1;
    reset_s[0]  = 1'b0;
    wait_empty(0, 3000);

    // Drop enable inside MEASURE_E, then restart from the retained delay.
    tick(20);
    enable_s[0] = 1'b0;
    tick(1);
    chk("abort op", int'(op_s[0]), 0);
    chk("abort locked", int'(lk_s[0]), 0);
    chk("abort dd", int'(dd_s[0]), 256);
    tick(4);
    push_round(0, 256, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    enable_s[0] = 1'b1;
    wait_empty(0, 20);

    // Early side always one bit wrong: step up once per round.
    reset_s[0] = 1'b1;
    tick(2);
    n_early[0] = 256; n_late[0] = 0;
    for (int k = 0; k < 4; k++)
      push_round(0, 256 + k, 1'b0, (k == 0) ? 0 : 256, 0, 256, k == 0, k < 3);
    reset_s[0] = 1'b0;
    wait_empty(0, 2500);
    tick(20);
    chk("step dd", int'(dd_s[0]), 259);
    chk("step early", int'(ee_s[0]), 256);
    reset_s[0] = 1'b1;
    #1;
    check_reset(0, 256);

    // Difference equal to the hysteresis holds; one more error moves.
    tick(2);
    n_early[0] = 10; n_late[0] = 6;
    push_round(0, 256, 1'b0, 0, 0, 10, 1'b1, 1'b1);
    push_round(0, 256, 1'b0, 10, 6, 0, 1'b0, 1'b0);
    reset_s[0] = 1'b0;
    wait_empty(0, 1200);
    reset_s[0] = 1'b1;
    tick(2);
    n_early[0] = 11;
    push_round(0, 256, 1'b0, 0, 0, 11, 1'b1, 1'b1);
    push_round(0, 257, 1'b0, 11, 6, 0, 1'b0, 1'b0);
    reset_s[0] = 1'b0;
    wait_empty(0, 1200);
    reset_s[0] = 1'b1;
    enable_s[0] = 1'b0;

    // Late-side errors from INIT_DELAY=5: walk down to 0, hold, then lock.
    n_early[1] = 0; n_late[1] = 256;
    for (int k = 0; k < 10; k++)
      push_round(1, (k < 5) ? 5 - k : 0, k >= 9, 0, (k == 0) ? 0 : 256, 0, k == 0, k < 9);
    enable_s[1] = 1'b1;
    reset_s[1]  = 1'b0;
    wait_empty(1, 6000);
    tick(5);
    chk("floor dd", int'(dd_s[1]), 0);
    chk("floor locked", int'(lk_s[1]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
